// File: rtl/modexp_ctrl.sv
// Modular exponentiation controller: result = base^exp mod n.
// Left-to-right square-and-multiply. Every multiplication is delegated to an
// external modmult unit through the mm_* handshake. The base is reduced once
// (base*1 mod n), and then each exponent bit from MSB to LSB costs one square,
// plus one multiply when that bit is set.
module modexp_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic [WIDTH-1:0] base,
    input  logic [WIDTH-1:0] exp,
    input  logic [WIDTH-1:0] n,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             busy,
    output logic             err,
    output logic             mm_go,
    output logic [WIDTH-1:0] mm_a,
    output logic [WIDTH-1:0] mm_b,
    output logic [WIDTH-1:0] mm_n,
    input  logic [WIDTH-1:0] mm_result,
    input  logic             mm_done
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP_ISSUE,
        S_PREP_WAIT,
        S_SQ_ISSUE,
        S_SQ_WAIT,
        S_MUL_ISSUE,
        S_MUL_WAIT,
        S_FINISH
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_base;
    logic [WIDTH-1:0] r_exp;
    logic [WIDTH-1:0] r_n;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_rb;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_mm_a;
    logic [WIDTH-1:0] r_mm_b;
    logic [IW-1:0]    r_idx;
    logic             r_done;
    logic             r_busy;
    logic             r_err;
    logic             r_mm_go;
    logic             r_mm_done_d;

    logic             w_mm_fire;
    logic             w_exp_bit;
    logic             w_last_bit;

    // A completion is a fresh rising edge of mm_done, so a done level held
    // over from the previous multiplication is never mistaken for a new one.
    assign w_mm_fire  = mm_done & ~r_mm_done_d;
    assign w_exp_bit  = r_exp[r_idx];
    assign w_last_bit = (r_idx == '0);

    assign result = r_result;
    assign done   = r_done;
    assign busy   = r_busy;
    assign err    = r_err;
    assign mm_go  = r_mm_go;
    assign mm_a   = r_mm_a;
    assign mm_b   = r_mm_b;
    assign mm_n   = r_n;

    // Delayed copy of mm_done for the rising-edge completion detect.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register in the design updates from the same pre-edge values.
        if (!rst) begin
            r_mm_done_d <= 1'b0;
        end else begin
            r_mm_done_d <= mm_done;
        end
    end

    // Main controller: walks the exponent bits and sequences modmult calls.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_base   <= '0;
            r_exp    <= '0;
            r_n      <= '0;
            r_acc    <= '0;
            r_rb     <= '0;
            r_result <= '0;
            r_mm_a   <= '0;
            r_mm_b   <= '0;
            r_idx    <= '0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
            r_err    <= 1'b0;
            r_mm_go  <= 1'b0;
        end else begin
            // Pulse outputs default low; only FINISH and the ISSUE states raise them.
            r_done  <= 1'b0;
            r_mm_go <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    // A go coinciding with the done pulse waits one cycle.
                    if (go && !r_done) begin
                        r_base <= base;
                        r_exp  <= exp;
                        r_n    <= n;
                        r_err  <= 1'b0;
                        r_idx  <= IW'(WIDTH - 1);
                        r_busy <= 1'b1;
                        if (n <= WIDTH'(1)) begin
                            // Modulus 0 or 1: result is 0 without any multiplication.
                            r_acc   <= '0;
                            r_state <= S_FINISH;
                        end else begin
                            r_state <= S_PREP_ISSUE;
                        end
                    end
                end

                S_PREP_ISSUE: begin
                    r_mm_a  <= r_base;
                    r_mm_b  <= WIDTH'(1);
                    r_mm_go <= 1'b1;
                    r_state <= S_PREP_WAIT;
                end

                S_PREP_WAIT: begin
                    if (w_mm_fire) begin
                        r_rb    <= mm_result;
                        r_acc   <= WIDTH'(1);
                        r_state <= S_SQ_ISSUE;
                    end
                end

                S_SQ_ISSUE: begin
                    r_mm_a  <= r_acc;
                    r_mm_b  <= r_acc;
                    r_mm_go <= 1'b1;
                    r_state <= S_SQ_WAIT;
                end

                S_SQ_WAIT: begin
                    if (w_mm_fire) begin
                        r_acc <= mm_result;
                        if (w_exp_bit) begin
                            r_state <= S_MUL_ISSUE;
                        end else if (w_last_bit) begin
                            r_state <= S_FINISH;
                        end else begin
                            r_idx   <= r_idx - IW'(1);
                            r_state <= S_SQ_ISSUE;
                        end
                    end
                end

                S_MUL_ISSUE: begin
                    r_mm_a  <= r_acc;
                    r_mm_b  <= r_rb;
                    r_mm_go <= 1'b1;
                    r_state <= S_MUL_WAIT;
                end

                S_MUL_WAIT: begin
                    if (w_mm_fire) begin
                        r_acc <= mm_result;
                        if (w_last_bit) begin
                            r_state <= S_FINISH;
                        end else begin
                            r_idx   <= r_idx - IW'(1);
                            r_state <= S_SQ_ISSUE;
                        end
                    end
                end

                S_FINISH: begin
                    r_result <= r_acc;
                    r_err    <= (r_n == '0);
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                    r_state  <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_modexp_ctrl.sv
// Self-checking bench for modexp_ctrl. A behavioural modmult answers the
// controller's multiplication requests with random latency, optionally holding
// done high until its next go. The driver pushes expected results from a plain
// repeated-multiplication reference into a scoreboard; the monitor pops and
// compares on each done pulse.
module tb_modexp_ctrl;

    localparam int WIDTH = 16;

    typedef struct {
        logic [WIDTH-1:0] res;
        logic             err;
        int               ops;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             go = 1'b0;
    logic [WIDTH-1:0] base_i = '0;
    logic [WIDTH-1:0] exp_i = '0;
    logic [WIDTH-1:0] n_i = '0;
    logic [WIDTH-1:0] result;
    logic             done;
    logic             busy;
    logic             err;
    logic             mm_go;
    logic [WIDTH-1:0] mm_a;
    logic [WIDTH-1:0] mm_b;
    logic [WIDTH-1:0] mm_n;
    logic [WIDTH-1:0] mm_result = '0;
    logic             mm_done = 1'b0;

    exp_t sb_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   done_seen = 0;
    int   lat_max = 4;
    bit   hold_mode = 1'b0;
    int   mm_cnt = 0;
    bit   mm_run = 1'b0;

    modexp_ctrl #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .go       (go),
        .base     (base_i),
        .exp      (exp_i),
        .n        (n_i),
        .result   (result),
        .done     (done),
        .busy     (busy),
        .err      (err),
        .mm_go    (mm_go),
        .mm_a     (mm_a),
        .mm_b     (mm_b),
        .mm_n     (mm_n),
        .mm_result(mm_result),
        .mm_done  (mm_done)
    );

    always #5 clk = ~clk;

    // Behavioural modmult: product mod n after a random delay.
    always @(posedge clk) begin
        if (mm_go) begin
            mm_run    <= 1'b1;
            mm_cnt    <= int'($urandom_range(lat_max - 1, 0));
            mm_done   <= 1'b0;
            mm_result <= (mm_n == '0) ? '0
                       : WIDTH'((longint'(mm_a) * longint'(mm_b)) % longint'(mm_n));
        end else if (mm_run) begin
            if (mm_cnt == 0) begin
                mm_done <= 1'b1;
                mm_run  <= 1'b0;
            end else begin
                mm_cnt <= mm_cnt - 1;
            end
        end else if (!hold_mode) begin
            mm_done <= 1'b0;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Reference: base^exp mod n by exp repeated multiplications.
    function automatic logic [WIDTH-1:0] ref_modexp(input longint b, input longint e, input longint m);
        longint r;
        if (m <= 1) return '0;
        r = 1;
        for (longint k = 0; k < e; k++) r = (r * (b % m)) % m;
        return WIDTH'(r);
    endfunction

    // Monitor: counts mm_go pulses per operation and checks each done pulse.
    initial begin
        int   op_cnt;
        exp_t e;
        op_cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                op_cnt = 0;
            end else begin
                if (mm_go) op_cnt++;
                if (done) begin
                    done_seen++;
                    if (sb_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_done: got result %0d, expected no done", result);
                    end else begin
                        e = sb_q.pop_front();
                        check("result", 64'(result), 64'(e.res));
                        check("err", 64'(err), 64'(e.err));
                        check("mm_go_count", 64'(op_cnt), 64'(e.ops));
                        check("busy_at_done", 64'(busy), 64'(0));
                    end
                    op_cnt = 0;
                end
            end
        end
    end

    task automatic start_op(input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] e, input logic [WIDTH-1:0] m);
        exp_t x;
        x.res = ref_modexp(longint'(b), longint'(e), longint'(m));
        x.err = (m == '0);
        x.ops = (m > 1) ? 1 + WIDTH + $countones(e) : 0;
        sb_q.push_back(x);
        @(negedge clk);
        go = 1'b1; base_i = b; exp_i = e; n_i = m;
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic wait_done(input int target);
        int t;
        t = 0;
        while (done_seen < target && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (done_seen < target) begin
            vectors++;
            miscompares++;
            $display("FAIL done_timeout: got %0d done pulses, expected %0d", done_seen, target);
            sb_q.delete();
            apply_reset();
        end
    endtask

    task automatic run_op(input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] e, input logic [WIDTH-1:0] m);
        int tgt;
        tgt = done_seen + 1;
        start_op(b, e, m);
        wait_done(tgt);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_result"}, 64'(result), 64'(0));
        check({tag, "_done"}, 64'(done), 64'(0));
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_err"}, 64'(err), 64'(0));
        check({tag, "_mm_go"}, 64'(mm_go), 64'(0));
        check({tag, "_mm_a"}, 64'(mm_a), 64'(0));
        check({tag, "_mm_b"}, 64'(mm_b), 64'(0));
        check({tag, "_mm_n"}, 64'(mm_n), 64'(0));
    endtask

    // Driver: directed cases, robustness scenarios, then randomized traffic.
    initial begin
        int tgt;
        int pulses;
        int t;
        logic [WIDTH-1:0] rn;

        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 check_all_zero("reset");
        rst = 1'b1;

        run_op(16'd4, 16'd13, 16'd497);
        run_op(16'd13, 16'd11, 16'd17);
        run_op(16'd2, 16'd10, 16'd1000);
        run_op(16'd100, 16'd3, 16'd17);
        run_op(16'd5, 16'd0, 16'd17);
        run_op(16'd1234, 16'd77, 16'd1);
        run_op(16'd9, 16'd9, 16'd0);
        run_op(16'd4, 16'd13, 16'd497);

        // A second go mid-operation must not disturb the first one.
        tgt = done_seen + 1;
        start_op(16'd4, 16'd13, 16'd497);
        repeat (12) @(negedge clk);
        go = 1'b1; base_i = 16'd7; exp_i = 16'd5; n_i = 16'd33;
        @(negedge clk);
        go = 1'b0;
        wait_done(tgt);
        repeat (40) @(negedge clk);

        // Reset during the first square's wait: everything clears.
        start_op(16'd4, 16'd13, 16'd497);
        pulses = 0;
        t = 0;
        while (pulses < 2 && t < 500) begin
            @(negedge clk);
            if (mm_go) pulses++;
            t++;
        end
        check("abort_reached_sq_wait", 64'(pulses), 64'(2));
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1 check_all_zero("abort");
        @(posedge clk);
        #1 rst = 1'b1;
        if (sb_q.size() > 0) void'(sb_q.pop_back());
        repeat (20) @(negedge clk);
        run_op(16'd13, 16'd11, 16'd17);

        // modmult holding done high until its next go.
        hold_mode = 1'b1;
        run_op(16'd4, 16'd13, 16'd497);
        for (int k = 0; k < 20; k++) begin
            lat_max = int'($urandom_range(6, 1));
            rn = (k % 4 == 0) ? WIDTH'($urandom_range(20, 0)) : WIDTH'($urandom_range(65535, 2));
            run_op(WIDTH'($urandom), WIDTH'($urandom), rn);
        end

        hold_mode = 1'b0;
        for (int k = 0; k < 20; k++) begin
            lat_max = int'($urandom_range(6, 1));
            rn = (k % 4 == 0) ? WIDTH'($urandom_range(20, 0)) : WIDTH'($urandom_range(65535, 2));
            run_op(WIDTH'($urandom), WIDTH'($urandom), rn);
        end

        repeat (20) @(negedge clk);
        check("scoreboard_drained", 64'(sb_q.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/modexp_ctrl.md
Name: modexp_ctrl

Overview:
- Modular exponentiation controller: computes result = base^exp mod n.
- Sits directly upstream of modmult. It owns the modmult operand/go inputs and consumes modmult's result/done.
- Uses left-to-right square-and-multiply. It forms the core of the RSA encrypt/decrypt path, where the top level wires it to one modmult instance.

Parameters:
- WIDTH, 16, bit width of base, exp, n, result and all modmult operands (must match the attached modmult).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  reset: synchronous, active-low (0 = reset, sampled on rising clk).
- go  input  1  start request; sampled only in IDLE.
- base  input  WIDTH  message/ciphertext; latched on accepted go.
- exp  input  WIDTH  exponent; latched on accepted go.
- n  input  WIDTH  modulus; latched on accepted go.
- result  output  WIDTH  base^exp mod n; valid when done=1, held until next accepted go.
- done  output  1  one-cycle pulse when result is valid.
- busy  output  1  high from the cycle after an accepted go until the cycle done pulses.
- err  output  1  set with done when n==0, cleared on next accepted go.
- mm_go  output  1  one-cycle start pulse to modmult.
- mm_a  output  WIDTH  modmult operand a; stable from mm_go until completion.
- mm_b  output  WIDTH  modmult operand b; stable from mm_go until completion.
- mm_n  output  WIDTH  modmult modulus (latched n).
- mm_result  input  WIDTH  modmult product.
- mm_done  input  1  modmult completion.

Behaviour:
- Reset (rst=0 at a rising clk) applies the following, regardless of state, including mid-operation:
  - state returns to IDLE;
  - result, done, busy, err, mm_go, mm_a, mm_b and mm_n all go to 0;
  - any in-flight modmult completion is ignored.
- Completion detect: a rising edge of mm_done, from an internal 1-cycle delayed copy. A done level held high over from a previous op is never treated as completion.
- State machine states: IDLE, PREP_ISSUE, PREP_WAIT, SQ_ISSUE, SQ_WAIT, MUL_ISSUE, MUL_WAIT, FINISH.
- IDLE, go=1: latch base, exp and n; clear err; set bit index i=WIDTH-1; set busy=1. Then branch:
  - n==0: go to FINISH with result=0 and err=1.
  - n==1: go to FINISH with result=0.
  - otherwise: go to PREP_ISSUE.
  - go while busy is ignored; latched operands do not change.
- PREP_ISSUE / PREP_WAIT: reduce base once as base*1 mod n.
  - Issue with mm_a=base, mm_b=1; store the product as rb (reduced base).
  - Set accumulator acc=1, then go to SQ_ISSUE.
- SQ_ISSUE / SQ_WAIT: issue with mm_a=acc, mm_b=acc; on completion acc <= mm_result.
  - If exp[i]=1, go to MUL_ISSUE.
  - Otherwise, if i==0 go to FINISH, else decrement i and go to SQ_ISSUE.
- MUL_ISSUE / MUL_WAIT: issue with mm_a=acc, mm_b=rb; on completion acc <= mm_result.
  - If i==0 go to FINISH, else decrement i and go to SQ_ISSUE.
- Every ISSUE state drives mm_go=1 for exactly one cycle and moves to its WAIT state on the next clk. Operands are registered and held constant through the WAIT state.
- FINISH: result <= acc (or the short-circuit value), done=1 for one cycle, busy=0, return to IDLE.
  - A go arriving in the same cycle done is high is not accepted. It is accepted the next cycle in IDLE.
- exp==0 (n>1): all squares of 1, no multiplies; result=1.
- Operation count for n>1 is exactly 1 + WIDTH + popcount(exp) mm_go pulses. No leading-zero skipping.
- Latency is that count × (modmult latency + 2) + 2 cycles. Total latency has no fixed bound and depends on the attached modmult.
- All arithmetic is delegated to modmult. Internal regs acc and rb are WIDTH bits and always < n after PREP.

Test Plan:
- WIDTH=16, base=4, exp=13, n=497, pulse go -> result=445, done pulses once, err=0, exactly 20 mm_go pulses (1+16+3).
- base=13, exp=11, n=17 -> result=4; base=2, exp=10, n=1000 -> result=24.
- base=100 (>n), exp=3, n=17 -> result=9 (base reduced to 15 in PREP).
- Edge cases:
  - exp=0, n=17 -> result=1.
  - n=1, any base/exp -> result=0 with no mm_go pulses.
  - n=0 -> result=0, err=1, no mm_go pulses; the next valid op clears err.
- Robustness:
  - Pulse go again mid-operation with different operands -> ignored; first result (445) is returned.
  - Assert rst=0 for one cycle during SQ_WAIT -> all outputs 0, state IDLE next cycle; a following go produces a correct result.
  - Use a modmult model that holds done high until the next go; results must still be correct.
